seg_capture: RTL

Seven-segment capture monitor: the receive end of the board's multiplexed seven-segment display interface. It samples the segment lines (a–g, dp) together with the one-hot digit-enable lines. It waits for each digit slot to hold steady, then decodes the segment pattern back to a 4-bit decimal value and stores it per digit. It sits on the test/loopback path so the FPGA can read back what the display driver is actually showing, and it flags glitches and illegal patterns.

---
 rtl/seg_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seg_capture.sv
// Seven-segment capture monitor: samples the multiplexed segment/enable lines,
// waits for each digit slot to settle, and stores the decoded value per slot.
module seg_capture #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a,
    input  logic                  b,
    input  logic                  c,
    input  logic                  d,
    input  logic                  e,
    input  logic                  f,
    input  logic                  g,
    input  logic                  dp,
    input  logic [N_DIGITS-1:0]   an,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   valid,
    output logic [N_DIGITS-1:0]   blank,
    output logic [N_DIGITS-1:0]   err,
    output logic [N_DIGITS-1:0]   dp_out,
    output logic                  update,
    output logic [2:0]            update_idx,
    output logic                  conflict
);

    localparam int SW = N_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         samp_q, samp_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic [N_DIGITS-1:0]   err_q, err_d;
    logic [N_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic                  update_q, update_d;
    logic [2:0]            update_idx_q, update_idx_d;
    logic                  conflict_q, conflict_d;

    logic [N_DIGITS-1:0] an_new;
    logic [6:0]          seg_new;
    logic                dp_new;
    logic                one_hot_new;
    logic                changed;
    logic                commit;
    logic [2:0]          slot_idx;
    logic [5:0]          dec;

    // Returns {legal, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode = {2'b10, 4'd0};
            7'b0110000: decode = {2'b10, 4'd1};
            7'b1101101: decode = {2'b10, 4'd2};
            7'b1111001: decode = {2'b10, 4'd3};
            7'b0110011: decode = {2'b10, 4'd4};
            7'b1011011: decode = {2'b10, 4'd5};
            7'b1011111: decode = {2'b10, 4'd6};
            7'b1110000: decode = {2'b10, 4'd7};
            7'b1111111: decode = {2'b10, 4'd8};
            7'b1110011: decode = {2'b10, 4'd9};
            7'b0000000: decode = {2'b01, 4'd0};
            default:    decode = {2'b00, 4'd0};
        endcase
    endfunction

    // The FSM judges the sample being loaded into S against the one it replaces,
    // so state and counter always describe the contents of S after the edge.
    assign samp_d      = {an, a, b, c, d, e, f, g, dp};
    assign an_new      = samp_d[SW-1 -: N_DIGITS];
    assign seg_new     = samp_d[7:1];
    assign dp_new      = samp_d[0];
    assign one_hot_new = $onehot(an_new);
    assign changed     = (samp_d != samp_q);
    assign dec         = decode(seg_new);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot_new) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_d = one_hot_new ? SETTLE : IDLE;
                    cnt_d   = one_hot_new ? CW'(1) : '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (changed) begin
                    state_d = one_hot_new ? SETTLE : IDLE;
                    cnt_d   = one_hot_new ? CW'(1) : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (an_new[i]) slot_idx = 3'(i);
        end
    end

    always_comb begin
        digits_d     = digits_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        err_d        = err_q;
        dp_out_d     = dp_out_q;
        update_d     = commit;
        update_idx_d = commit ? slot_idx : update_idx_q;
        conflict_d   = (an_new != '0) && !one_hot_new;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (commit && an_new[i]) begin
                valid_d[i]  = dec[5];
                blank_d[i]  = dec[4];
                err_d[i]    = !dec[5] && !dec[4];
                dp_out_d[i] = dp_new;
                // An illegal pattern keeps the last good value in the slot.
                if (dec[5] || dec[4]) digits_d[4*i +: 4] = dec[3:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            samp_q       <= '0;
            digits_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            err_q        <= '0;
            dp_out_q     <= '0;
            update_q     <= 1'b0;
            update_idx_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            samp_q       <= samp_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            dp_out_q     <= dp_out_d;
            update_q     <= update_d;
            update_idx_q <= update_idx_d;
            conflict_q   <= conflict_d;
        end
    end

    assign digits     = digits_q;
    assign valid      = valid_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign dp_out     = dp_out_q;
    assign update     = update_q;
    assign update_idx = update_idx_q;
    assign conflict   = conflict_q;

endmodule
